// File: rtl/compare_checker.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : compare_checker
// Description : Scores a blocking and a non-blocking two-stage shift register
//               against a delayed copy of their shared stimulus. It keeps a
//               saturating mismatch count per device and the first mismatch
//               index.
// Revision    : 1.0
// ============================================================================
module compare_checker #(
  parameter int unsigned NUM_SAMPLES = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] a,
  input  logic [3:0] b1,
  input  logic [3:0] c1,
  input  logic [3:0] b2,
  input  logic [3:0] c2,
  input  logic       start,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       pass_b,
  output logic       pass_nb,
  output logic [7:0] err_cnt_b,
  output logic [7:0] err_cnt_nb,
  output logic [7:0] first_err_idx
);

  localparam logic [7:0] LAST_IDX = 8'(NUM_SAMPLES - 1);
  localparam logic [7:0] NO_ERR   = 8'hFF;
  localparam logic [7:0] CNT_MAX  = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WARMUP = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] a_d1_q, a_d1_d;
  logic [3:0] a_d2_q, a_d2_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] cnt_b_q, cnt_b_d;
  logic [7:0] cnt_nb_q, cnt_nb_d;
  logic [7:0] first_q, first_d;
  logic       mis_b, mis_nb;

  // Blocking register collapses both stages onto the newest history value.
  assign mis_b  = (b1 != a_d1_q) || (c1 != a_d1_q);
  assign mis_nb = (b2 != a_d1_q) || (c2 != a_d2_q);

  always_comb begin
    state_d  = state_q;
    a_d1_d   = a_d1_q;
    a_d2_d   = a_d2_q;
    idx_d    = idx_q;
    cnt_b_d  = cnt_b_q;
    cnt_nb_d = cnt_nb_q;
    first_d  = first_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            cnt_b_d  = 8'd0;
            cnt_nb_d = 8'd0;
            first_d  = NO_ERR;
            a_d1_d   = a;
            state_d  = S_WARMUP;
          end
        end
        S_WARMUP: begin
          a_d2_d  = a_d1_q;
          a_d1_d  = a;
          idx_d   = 8'd0;
          state_d = S_CHECK;
        end
        S_CHECK: begin
          if (mis_b && (cnt_b_q != CNT_MAX)) cnt_b_d = cnt_b_q + 8'd1;
          if (mis_nb && (cnt_nb_q != CNT_MAX)) cnt_nb_d = cnt_nb_q + 8'd1;
          // Index never reaches 0xFF during a run, so 0xFF safely means "none yet".
          if ((mis_b || mis_nb) && (first_q == NO_ERR)) first_d = idx_q;
          a_d2_d = a_d1_q;
          a_d1_d = a;
          idx_d  = idx_q + 8'd1;
          if (idx_q == LAST_IDX) state_d = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_d1_q   <= 4'd0;
      a_d2_q   <= 4'd0;
      idx_q    <= 8'd0;
      cnt_b_q  <= 8'd0;
      cnt_nb_q <= 8'd0;
      first_q  <= NO_ERR;
    end else begin
      state_q  <= state_d;
      a_d1_q   <= a_d1_d;
      a_d2_q   <= a_d2_d;
      idx_q    <= idx_d;
      cnt_b_q  <= cnt_b_d;
      cnt_nb_q <= cnt_nb_d;
      first_q  <= first_d;
    end
  end

  assign busy          = (state_q == S_WARMUP) || (state_q == S_CHECK);
  assign done          = (state_q == S_DONE);
  assign pass_b        = done && (cnt_b_q == 8'd0);
  assign pass_nb       = done && (cnt_nb_q == 8'd0);
  assign err_cnt_b     = cnt_b_q;
  assign err_cnt_nb    = cnt_nb_q;
  assign first_err_idx = first_q;

endmodule

`default_nettype wire

// File: doc/compare_checker.md
COMPARE_CHECKER -- requirements
Module: compare_checker

Interface
REQ-001 The block SHALL have parameter NUM_SAMPLES, default 5, giving the number of compared cycles per run (legal range 1..255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port a, input, 4 bits: the stimulus value driven into both devices under test.
REQ-005 The block SHALL have ports b1 and c1, input, 4 bits each: outputs of the blocking-assignment shift register.
REQ-006 The block SHALL have ports b2 and c2, input, 4 bits each: outputs of the non-blocking-assignment shift register.
REQ-007 The block SHALL have port start, input, 1 bit: begins a run when sampled high in IDLE or DONE.
REQ-008 The block SHALL have port abort, input, 1 bit: terminates any run and returns to IDLE.
REQ-009 The block SHALL have port busy, output, 1 bit: high in WARMUP and CHECK.
REQ-010 The block SHALL have port done, output, 1 bit: high in DONE.
REQ-011 The block SHALL have ports pass_b and pass_nb, output, 1 bit each: high in DONE when the error count of the respective device is 0.
REQ-012 The block SHALL have ports err_cnt_b and err_cnt_nb, output, 8 bits each: mismatching-cycle counts per device.
REQ-013 The block SHALL have port first_err_idx, output, 8 bits: CHECK-cycle index (0-based) of the first mismatch on either device; 8'hFF means no mismatch.

Function
REQ-014 The block SHALL implement a four-state FSM: IDLE, WARMUP, CHECK, DONE.
REQ-015 In IDLE or DONE, start=1 SHALL do all of the following on that edge: clear the counters, set first_err_idx to 8'hFF, load a_d1<=a, and go to WARMUP.
REQ-016 WARMUP SHALL last exactly one cycle: shift a_d2<=a_d1 and a_d1<=a, then go to CHECK with sample index 0.
REQ-017 On each CHECK edge, the non-blocking device SHALL mismatch when b2!=a_d1 or c2!=a_d2, using the pre-edge history values.
REQ-018 On each CHECK edge, the blocking device SHALL mismatch when b1!=a_d1 or c1!=a_d1, using the pre-edge history values.
REQ-019 Each mismatching cycle SHALL add exactly 1 to that device's counter, irrespective of how many of its bits or outputs differ.
REQ-020 The error counters SHALL saturate at 255 and never wrap.
REQ-021 On the first CHECK cycle with any mismatch, first_err_idx SHALL capture the sample index and SHALL hold it afterwards.
REQ-022 After each compare, the history SHALL shift (a_d2<=a_d1, a_d1<=a) and the sample index SHALL increment.
REQ-023 After the compare at index NUM_SAMPLES-1, the block SHALL go to DONE.
REQ-024 In DONE, the results SHALL hold until start or abort; the pass_* outputs SHALL be 0 outside DONE.
REQ-025 start in WARMUP or CHECK SHALL be ignored.
REQ-026 abort SHALL take priority over start in every state.
REQ-027 abort SHALL go to IDLE on the next edge without updating the counters on that edge; the counters SHALL retain their values.
REQ-028 The compare latency SHALL be 1 clock: a mismatch visible on the inputs before edge t SHALL be reflected in the counters after edge t.

Reset
REQ-029 rst_n=0 SHALL immediately, without a clock edge, force: state IDLE, busy=0, done=0, pass_b=0, pass_nb=0, err_cnt_b=0, err_cnt_nb=0, first_err_idx=8'hFF, a_d1=0, a_d2=0, sample index 0.
REQ-030 Reset asserted mid-CHECK SHALL abandon the run with no DONE pulse; the block SHALL then require a new start.
REQ-031 Release of rst_n SHALL be the only event that exits reset; the first active edge after release SHALL evaluate from IDLE.

Verification
REQ-032 The bench SHALL run correct DUTs on a 100 ns clock with a=3,7,F,A,2 changed every cycle and a start pulse -> done after 6 cycles, pass_b=1, pass_nb=1, both counters 0, first_err_idx=FF.
REQ-033 The bench SHALL feed the blocking DUT outputs into b2/c2 with the same sequence -> err_cnt_nb=5, first_err_idx=0, pass_nb=0, err_cnt_b=0.
REQ-034 The bench SHALL use NUM_SAMPLES=255 with c1 stuck at 0 and a never 0 -> err_cnt_b=255 saturated, no wrap, pass_b=0.
REQ-035 The bench SHALL assert rst_n low at CHECK index 2 -> all outputs at reset values immediately; a later start SHALL yield a clean run.
REQ-036 The bench SHALL pulse start during CHECK, then assert abort and start together -> start ignored; block in IDLE, busy=0, counters retained.
